// File: rtl/multi_adder_pkg.sv
// Shared width helpers and the stage-valid type for the pipelined multi-operand adder.
// Optional two's-complement mode is selected with the MULTI_ADDER_SIGNED_EN macro in the top.
package multi_adder_pkg;

    typedef logic stage_valid_t;

    function automatic int sum_width(input int n, input int ops);
        return n + $clog2(ops);
    endfunction

    // Operand count rounded up to a power of two; missing leaves are zero.
    function automatic int pad_ops(input int ops);
        return 1 << $clog2(ops);
    endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One registered adder-tree level: IN_CNT operands in, IN_CNT/2 pairwise sums out,
// with a valid bit and local advance logic for a valid/ready chain.
module adder_tree_stage
    import multi_adder_pkg::*;
#(
    parameter int IN_CNT = 2,
    parameter int W      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [IN_CNT*W-1:0]       data_i,
    input  stage_valid_t              valid_i,
    input  logic                      ready_i,
    output logic [(IN_CNT/2)*W-1:0]   data_o,
    output stage_valid_t              valid_o,
    output logic                      ready_o
);

    localparam int OUT_CNT = IN_CNT / 2;

    logic [OUT_CNT*W-1:0] pair_sum;
    logic [OUT_CNT*W-1:0] data_q;
    logic [OUT_CNT*W-1:0] data_d;
    stage_valid_t         valid_q;
    stage_valid_t         valid_d;
    logic                 load;

    // A stage may load when empty or when its current contents leave this cycle.
    assign ready_o = !valid_q || ready_i;
    assign load    = valid_i && ready_o;

    always_comb begin
        pair_sum = '0;
        for (int j = 0; j < OUT_CNT; j++) begin
            pair_sum[j*W +: W] = data_i[2*j*W +: W] + data_i[(2*j+1)*W +: W];
        end
    end

    always_comb begin
        data_d  = load ? pair_sum : data_q;
        valid_d = load ? 1'b1 : (ready_i ? 1'b0 : valid_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pipelined_multi_adder.sv
// Pipelined NUM_OPS-operand adder: one registered tree level per stage, valid/ready on both sides.
// Define MULTI_ADDER_SIGNED_EN for two's-complement operands (sign extension at level 0).
module pipelined_multi_adder
    import multi_adder_pkg::*;
#(
    parameter  int N       = 8,
    parameter  int NUM_OPS = 8,
    localparam int LEVELS  = $clog2(NUM_OPS),
    localparam int SUM_W   = sum_width(N, NUM_OPS),
    localparam int PAD     = pad_ops(NUM_OPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in [NUM_OPS],
    input  logic             in_valid,
    output logic             in_ready,
    output logic [SUM_W-1:0] sum,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [PAD*SUM_W-1:0] lvl0;
    logic [LEVELS-1:0]    stg_valid;
    logic [LEVELS:0]      stg_ready;

    for (genvar i = 0; i < PAD; i++) begin : g_op
        if (i < NUM_OPS) begin : g_real
`ifdef MULTI_ADDER_SIGNED_EN
            assign lvl0[i*SUM_W +: SUM_W] = {{(SUM_W-N){in[i][N-1]}}, in[i]};
`else
            assign lvl0[i*SUM_W +: SUM_W] = {{(SUM_W-N){1'b0}}, in[i]};
`endif
        end else begin : g_pad
            assign lvl0[i*SUM_W +: SUM_W] = '0;
        end
    end

    assign stg_ready[LEVELS] = out_ready;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        logic [(PAD>>k)*SUM_W-1:0]     din;
        logic [(PAD>>(k+1))*SUM_W-1:0] dout;
        logic                          vin;

        if (k == 0) begin : g_first
            assign din = lvl0;
            assign vin = in_valid;
        end else begin : g_next
            assign din = g_lvl[k-1].dout;
            assign vin = stg_valid[k-1];
        end

        adder_tree_stage #(
            .IN_CNT (PAD >> k),
            .W      (SUM_W)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .data_i  (din),
            .valid_i (vin),
            .ready_i (stg_ready[k+1]),
            .data_o  (dout),
            .valid_o (stg_valid[k]),
            .ready_o (stg_ready[k])
        );
    end

    // in_ready depends only on stage valids and out_ready, never on in_valid.
    assign in_ready  = stg_ready[0];
    assign sum       = g_lvl[LEVELS-1].dout;
    assign out_valid = stg_valid[LEVELS-1];

endmodule

// File: tb/tb_pipelined_multi_adder.sv
// Bench for pipelined_multi_adder: an 8-operand and a 5-operand instance checked against
// an arithmetic reference model through expected-value queues.
module tb_pipelined_multi_adder;

    localparam int N      = 8;
    localparam int NA     = 8;
    localparam int NB     = 5;
    localparam int SUM_W  = 11;
    localparam int LEVELS = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0]     in_a [NA];
    logic             in_valid_a  = 1'b0;
    logic             in_ready_a;
    logic [SUM_W-1:0] sum_a;
    logic             out_valid_a;
    logic             out_ready_a = 1'b1;

    logic [N-1:0]     in_b [NB];
    logic             in_valid_b  = 1'b0;
    logic             in_ready_b;
    logic [SUM_W-1:0] sum_b;
    logic             out_valid_b;
    logic             out_ready_b = 1'b1;

    always #5 clk = ~clk;

    pipelined_multi_adder #(.N(N), .NUM_OPS(NA)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_a),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .sum       (sum_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a)
    );

    pipelined_multi_adder #(.N(N), .NUM_OPS(NB)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_b),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .sum       (sum_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pops_a   = 0;
    int pops_b   = 0;

    logic [SUM_W-1:0] exp_a_q[$];
    logic [SUM_W-1:0] exp_b_q[$];
    int               lat_a_q[$];
    int               lat_b_q[$];

    bit               chk_lat_a  = 1'b0;
    bit               last_acc_a = 1'b0;
    bit               prev_stall = 1'b0;
    logic [SUM_W-1:0] prev_sum   = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d",
                     tag, act, act, exp, exp, cyc);
        end
    endtask

    // Reference: plain integer sum of the first nops operands, truncated to the result width.
    function automatic logic [SUM_W-1:0] ref_sum(input logic [N-1:0] v [NA], input int nops);
        int acc;
        acc = 0;
        for (int i = 0; i < nops; i++) begin
`ifdef MULTI_ADDER_SIGNED_EN
            acc += int'($signed(v[i]));
`else
            acc += int'(v[i]);
`endif
        end
        return acc[SUM_W-1:0];
    endfunction

    task automatic set_all_a(input int val);
        foreach (in_a[i]) in_a[i] = val[N-1:0];
    endtask

    // Scores the inputs currently driven, then advances one clock.
    task automatic tick();
        logic [N-1:0]     vb [NA];
        logic [SUM_W-1:0] e;
        int               l;
        #1;
        if (prev_stall) begin
            check_eq("hold_valid", 32'(out_valid_a), 32'd1);
            check_eq("hold_sum", 32'(sum_a), 32'(prev_sum));
        end
        last_acc_a = in_valid_a && in_ready_a;
        if (last_acc_a) begin
            exp_a_q.push_back(ref_sum(in_a, NA));
            lat_a_q.push_back(cyc);
        end
        if (out_valid_a && out_ready_a) begin
            if (exp_a_q.size() == 0) begin
                check_eq("a_unexpected_out", 32'(out_valid_a), 32'd0);
            end else begin
                e = exp_a_q.pop_front();
                l = lat_a_q.pop_front();
                check_eq("a_sum", 32'(sum_a), 32'(e));
                if (chk_lat_a) check_eq("a_latency", 32'(cyc - l), 32'(LEVELS));
                pops_a++;
            end
        end
        prev_stall = out_valid_a && !out_ready_a;
        prev_sum   = sum_a;

        foreach (vb[i]) vb[i] = '0;
        for (int i = 0; i < NB; i++) vb[i] = in_b[i];
        if (in_valid_b && in_ready_b) begin
            exp_b_q.push_back(ref_sum(vb, NB));
            lat_b_q.push_back(cyc);
        end
        if (out_valid_b && out_ready_b) begin
            if (exp_b_q.size() == 0) begin
                check_eq("b_unexpected_out", 32'(out_valid_b), 32'd0);
            end else begin
                e = exp_b_q.pop_front();
                l = lat_b_q.pop_front();
                check_eq("b_sum", 32'(sum_b), 32'(e));
                check_eq("b_latency", 32'(cyc - l), 32'(LEVELS));
                pops_b++;
            end
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int budget);
        in_valid_a  = 1'b0;
        in_valid_b  = 1'b0;
        out_ready_a = 1'b1;
        for (int c = 0; c < budget && (exp_a_q.size() > 0 || exp_b_q.size() > 0); c++) tick();
        check_eq("drain_a_empty", 32'(exp_a_q.size()), 32'd0);
        check_eq("drain_b_empty", 32'(exp_b_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n_acc;
        set_all_a(0);
        foreach (in_b[i]) in_b[i] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_out_valid_a", 32'(out_valid_a), 32'd0);
        check_eq("rst_sum_a", 32'(sum_a), 32'd0);
        check_eq("rst_out_valid_b", 32'(out_valid_b), 32'd0);
        check_eq("rst_sum_b", 32'(sum_b), 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_in_ready", 32'(in_ready_a), 32'd1);

        // Three back-to-back vectors at full throughput, fixed latency
        chk_lat_a  = 1'b1;
        base       = pops_a;
        in_valid_a = 1'b1;
        in_a = '{8'd13, 8'd7, 8'd64, 8'd38, 8'd21, 8'd78, 8'd93, 8'd45};
        tick();
        check_eq("t1_accept0", 32'(last_acc_a), 32'd1);
        set_all_a(0);
        tick();
        check_eq("t1_accept1", 32'(last_acc_a), 32'd1);
        set_all_a(1);
        tick();
        check_eq("t1_accept2", 32'(last_acc_a), 32'd1);
        drain(10);
        check_eq("t1_pops", 32'(pops_a - base), 32'd3);

        // Maximum operands and the signed-mode extreme patterns
        in_valid_a = 1'b1;
        set_all_a(255);
        tick();
        set_all_a(128);
        tick();
        drain(10);
        chk_lat_a = 1'b0;

        // Five-operand instance
        base       = pops_b;
        in_b       = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        in_valid_b = 1'b1;
        tick();
        in_valid_b = 1'b0;
        drain(10);
        check_eq("b_pops", 32'(pops_b - base), 32'd1);

        // Back-pressure: only LEVELS vectors fit while the consumer stalls
        base        = pops_a;
        out_ready_a = 1'b0;
        n_acc       = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid_a = 1'b1;
            set_all_a(n_acc + 1);
            tick();
            if (last_acc_a) n_acc++;
        end
        check_eq("bp_accepts", 32'(n_acc), 32'd3);
        #1;
        check_eq("bp_in_ready", 32'(in_ready_a), 32'd0);
        out_ready_a = 1'b1;
        for (int c = 0; c < 10 && n_acc < 4; c++) begin
            tick();
            if (last_acc_a) n_acc++;
        end
        check_eq("bp_fourth_accept", 32'(n_acc), 32'd4);
        drain(20);
        check_eq("bp_pops", 32'(pops_a - base), 32'd4);

        // Random traffic on both instances
        for (int c = 0; c < 400; c++) begin
            in_valid_a  = ($urandom_range(0, 3) != 0);
            out_ready_a = ($urandom_range(0, 3) != 0);
            in_valid_b  = ($urandom_range(0, 1) != 0);
            foreach (in_a[i]) in_a[i] = N'($urandom_range(0, 255));
            foreach (in_b[i]) in_b[i] = N'($urandom_range(0, 255));
            tick();
        end
        drain(40);

        // Reset mid-operation: leave a nonzero value in the last stage first
        in_valid_a = 1'b1;
        set_all_a(1);
        tick();
        drain(10);
        in_valid_a = 1'b1;
        set_all_a(3);
        tick();
        set_all_a(4);
        tick();
        in_valid_a = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 32'(out_valid_a), 32'd0);
        check_eq("mid_rst_sum", 32'(sum_a), 32'd0);
        exp_a_q.delete();
        lat_a_q.delete();
        prev_stall = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("no_stale_out", 32'(out_valid_a), 32'd0);
        end
        base       = pops_a;
        chk_lat_a  = 1'b1;
        in_valid_a = 1'b1;
        set_all_a(1);
        tick();
        drain(10);
        check_eq("post_rst_pops", 32'(pops_a - base), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
